// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - control, redirect, loader and IF/ID signal bundle for fetch_unit
// FETCH_STEP_EN adds the single-step qualifier i_step.
interface fetch_unit_if #(
    parameter int NB_PC    = 32,
    parameter int NB_INSTR = 32,
    parameter int NB_ADDR  = 8
);
    logic                i_start;
    logic                i_stall_pc;
    logic                i_stall_IF_ID;
    logic                i_flush_IF_ID;
    logic                i_branch_taken;
    logic [NB_PC-1:0]    i_branch_target;
    logic                i_jump;
    logic [NB_PC-1:0]    i_jump_target;
    logic                i_WB_halt;
    logic                i_imem_we;
    logic [NB_ADDR-1:0]  i_imem_waddr;
    logic [NB_INSTR-1:0] i_imem_wdata;
`ifdef FETCH_STEP_EN
    logic                i_step;
`endif
    logic [NB_PC-1:0]    o_pc;
    logic [NB_INSTR-1:0] o_IF_ID_instr;
    logic [NB_PC-1:0]    o_IF_ID_pc4;
    logic                o_IF_ID_valid;
    logic                o_halted;
    logic [1:0]          o_state;

    modport master (
`ifdef FETCH_STEP_EN
        output i_step,
`endif
        output i_start, i_stall_pc, i_stall_IF_ID, i_flush_IF_ID,
        output i_branch_taken, i_branch_target, i_jump, i_jump_target,
        output i_WB_halt, i_imem_we, i_imem_waddr, i_imem_wdata,
        input  o_pc, o_IF_ID_instr, o_IF_ID_pc4, o_IF_ID_valid, o_halted, o_state
    );

    modport slave (
`ifdef FETCH_STEP_EN
        input  i_step,
`endif
        input  i_start, i_stall_pc, i_stall_IF_ID, i_flush_IF_ID,
        input  i_branch_taken, i_branch_target, i_jump, i_jump_target,
        input  i_WB_halt, i_imem_we, i_imem_waddr, i_imem_wdata,
        output o_pc, o_IF_ID_instr, o_IF_ID_pc4, o_IF_ID_valid, o_halted, o_state
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with loadable imem, IF/ID register and HALT tracking FSM
// FETCH_STEP_EN: RUN/HALT_SEEN advance only on i_step cycles.
module fetch_unit #(
    parameter int NB_PC      = 32,
    parameter int NB_INSTR   = 32,
    parameter int IMEM_DEPTH = 256
) (
    input  logic       i_clk,
    input  logic       i_reset,
    fetch_unit_if.slave bus
);
    localparam int NB_ADDR = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        HALT_SEEN = 2'd2,
        HALTED    = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [NB_PC-1:0]    pc;
    logic [NB_PC-1:0]    pc_next;
    logic [NB_PC-1:0]    pc_plus4;
    logic [NB_INSTR-1:0] ifid_instr;
    logic [NB_INSTR-1:0] ifid_instr_next;
    logic [NB_PC-1:0]    ifid_pc4;
    logic [NB_PC-1:0]    ifid_pc4_next;
    logic                ifid_valid;
    logic                ifid_valid_next;
    logic [NB_INSTR-1:0] imem [IMEM_DEPTH];
    logic [NB_INSTR-1:0] fetched;
    logic                advance;
    logic                redirect;
    logic                halt_load;

`ifdef FETCH_STEP_EN
    assign advance = bus.i_step;
`else
    assign advance = 1'b1;
`endif

    assign pc_plus4  = pc + NB_PC'(4);
    assign fetched   = imem[pc[NB_ADDR+1:2]];
    assign redirect  = bus.i_branch_taken | bus.i_jump;
    assign halt_load = (fetched[31:26] == 6'b111111) & ~bus.i_flush_IF_ID & ~bus.i_stall_IF_ID;

    // Loader port only; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (state == IDLE && bus.i_imem_we) begin
            imem[bus.i_imem_waddr] <= bus.i_imem_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.i_start) state_next = RUN;
            end
            RUN: begin
                // A redirect in the same cycle means the HALT is wrong-path.
                if (advance && !redirect && halt_load) state_next = HALT_SEEN;
            end
            HALT_SEEN: begin
                if (advance) begin
                    if (redirect)           state_next = RUN;
                    else if (bus.i_WB_halt) state_next = HALTED;
                end
            end
            default: state_next = state;
        endcase
    end

    always_comb begin
        pc_next         = pc;
        ifid_instr_next = ifid_instr;
        ifid_pc4_next   = ifid_pc4;
        ifid_valid_next = ifid_valid;
        case (state)
            RUN: begin
                if (advance) begin
                    if (bus.i_branch_taken)              pc_next = bus.i_branch_target;
                    else if (bus.i_jump)                 pc_next = bus.i_jump_target;
                    else if (bus.i_stall_pc || halt_load) pc_next = pc;
                    else                                 pc_next = pc_plus4;

                    if (bus.i_flush_IF_ID) begin
                        ifid_instr_next = '0;
                        ifid_pc4_next   = '0;
                        ifid_valid_next = 1'b0;
                    end else if (!bus.i_stall_IF_ID) begin
                        ifid_instr_next = fetched;
                        ifid_pc4_next   = pc_plus4;
                        ifid_valid_next = 1'b1;
                    end
                end
            end
            HALT_SEEN: begin
                if (advance) begin
                    if (bus.i_branch_taken) pc_next = bus.i_branch_target;
                    else if (bus.i_jump)    pc_next = bus.i_jump_target;

                    if (bus.i_flush_IF_ID || !bus.i_stall_IF_ID) begin
                        ifid_instr_next = '0;
                        ifid_pc4_next   = '0;
                        ifid_valid_next = 1'b0;
                    end
                end
            end
            default: begin
                pc_next = pc;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc         <= '0;
            ifid_instr <= '0;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else begin
            pc         <= pc_next;
            ifid_instr <= ifid_instr_next;
            ifid_pc4   <= ifid_pc4_next;
            ifid_valid <= ifid_valid_next;
        end
    end

    assign bus.o_pc          = pc;
    assign bus.o_IF_ID_instr = ifid_instr;
    assign bus.o_IF_ID_pc4   = ifid_pc4;
    assign bus.o_IF_ID_valid = ifid_valid;
    assign bus.o_halted      = (state == HALTED);
    assign bus.o_state       = state;
endmodule
